// File: rtl/clint_mh_if.sv
// Wishbone-B4 classic bus between a peripheral-bus master and the CLINT.
//   master: drives cyc/stb/addr/wdata/sel/we, receives rdata/ack/err
//   slave : the CLINT side of the same signals
interface clint_mh_if;
    logic        cyc;
    logic        stb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdata;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, addr, wdata, sel, we,
        input  rdata, ack, err
    );

    modport slave (
        input  cyc, stb, addr, wdata, sel, we,
        output rdata, ack, err
    );
endinterface

// File: rtl/clint_mh.sv
// Multi-hart core-local interruptor on a Wishbone-B4 classic slave port.
// One shared 64-bit mtime advanced by a prescaler; per hart an MSIP and SSIP bit
// plus 64-bit mtimecmp / stimecmp, both compared unsigned against mtime.
//
// Ports
//   clk                     clock
//   rst                     asynchronous reset, active high
//   bus                     Wishbone slave (cyc/stb/addr/wdata/sel/we -> rdata/ack/err)
//   clint_core_msoft_irq_o  per-hart machine software interrupt (msip)
//   clint_core_ssoft_irq_o  per-hart supervisor software interrupt (ssip)
//   clint_core_mtmr_irq_o   per-hart mtime >= mtimecmp
//   clint_core_stmr_irq_o   per-hart mtime >= stimecmp
//
// Register map (offset from BASE_ADDR, 64 KiB window)
//   0x0000 + 4h        MSIP[h]     bit0
//   0x1000 + 4h        SSIP[h]     bit0
//   0x4000 + 8h (+4)   MTIMECMP[h] lo (hi)
//   0x5000 + 8h (+4)   STIMECMP[h] lo (hi)
//   0xBFF0             CTRL        bit0 EN
//   0xBFF4             PRESCALE    [DIV_WIDTH-1:0]
//   0xBFF8 / 0xBFFC    MTIME lo / hi
//
// Bus handshake states
//   state  | meaning
//   S_IDLE | waiting for cyc&stb; decode and commit writes on the accepting edge
//   S_ACK  | mapped access done, ack (gated by cyc) with registered rdata
//   S_ERR  | unmapped access, err (gated by cyc), no state change
module clint_mh #(
    parameter int unsigned          NHART     = 1,
    parameter logic [31:0]          BASE_ADDR = 32'h0200_0000,
    parameter int unsigned          DIV_WIDTH = 16,
    parameter logic [DIV_WIDTH-1:0] PRESC_RST = '0,
    parameter logic [63:0]          CMP_RST   = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst,
    clint_mh_if.slave        bus,
    output logic [NHART-1:0] clint_core_msoft_irq_o,
    output logic [NHART-1:0] clint_core_ssoft_irq_o,
    output logic [NHART-1:0] clint_core_mtmr_irq_o,
    output logic [NHART-1:0] clint_core_stmr_irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [63:0]          mtime;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] prescale;
    logic                 en;
    logic [63:0]          mtimecmp [NHART];
    logic [63:0]          stimecmp [NHART];
    logic [NHART-1:0]     msip;
    logic [NHART-1:0]     ssip;
    logic [NHART-1:0]     msoft_q;
    logic [NHART-1:0]     ssoft_q;
    logic [NHART-1:0]     mtmr_q;
    logic [NHART-1:0]     stmr_q;
    logic [31:0]          rdata_q;

    logic [15:0]      off;
    logic             addr_ok;
    logic [NHART-1:0] msip_hit;
    logic [NHART-1:0] ssip_hit;
    logic [NHART-1:0] mcmp_lo_hit;
    logic [NHART-1:0] mcmp_hi_hit;
    logic [NHART-1:0] scmp_lo_hit;
    logic [NHART-1:0] scmp_hi_hit;
    logic             ctrl_hit;
    logic             presc_hit;
    logic             mtlo_hit;
    logic             mthi_hit;
    logic             mapped;
    logic             req;
    logic             wr;
    logic             tick;
    logic             mtime_wr;
    logic [31:0]      rd_val;

    // Byte-lane merge: lanes with sel set take the new data, the rest keep cur.
    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? wd[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- decode
    assign off     = bus.addr[15:0];
    assign addr_ok = (bus.addr[31:16] == BASE_ADDR[31:16]) && (bus.addr[1:0] == 2'b00);

    always_comb begin
        msip_hit    = '0;
        ssip_hit    = '0;
        mcmp_lo_hit = '0;
        mcmp_hi_hit = '0;
        scmp_lo_hit = '0;
        scmp_hi_hit = '0;
        // Only indices below NHART can ever match, so h >= NHART falls out as unmapped.
        for (int h = 0; h < NHART; h++) begin
            msip_hit[h]    = addr_ok && (off[15:12] == 4'h0) && (off[11:2] == 10'(h));
            ssip_hit[h]    = addr_ok && (off[15:12] == 4'h1) && (off[11:2] == 10'(h));
            mcmp_lo_hit[h] = addr_ok && (off[15:12] == 4'h4) && (off[11:3] == 9'(h)) && !off[2];
            mcmp_hi_hit[h] = addr_ok && (off[15:12] == 4'h4) && (off[11:3] == 9'(h)) &&  off[2];
            scmp_lo_hit[h] = addr_ok && (off[15:12] == 4'h5) && (off[11:3] == 9'(h)) && !off[2];
            scmp_hi_hit[h] = addr_ok && (off[15:12] == 4'h5) && (off[11:3] == 9'(h)) &&  off[2];
        end
    end

    assign ctrl_hit  = addr_ok && (off == 16'hBFF0);
    assign presc_hit = addr_ok && (off == 16'hBFF4);
    assign mtlo_hit  = addr_ok && (off == 16'hBFF8);
    assign mthi_hit  = addr_ok && (off == 16'hBFFC);

    assign mapped = |{msip_hit, ssip_hit, mcmp_lo_hit, mcmp_hi_hit, scmp_lo_hit, scmp_hi_hit,
                      ctrl_hit, presc_hit, mtlo_hit, mthi_hit};

    assign req      = bus.cyc && bus.stb && (state == S_IDLE);
    assign wr       = req && bus.we && mapped;
    assign mtime_wr = wr && (mtlo_hit || mthi_hit);

    always_comb begin
        rd_val = '0;
        for (int h = 0; h < NHART; h++) begin
            if (msip_hit[h])    rd_val = {31'd0, msip[h]};
            if (ssip_hit[h])    rd_val = {31'd0, ssip[h]};
            if (mcmp_lo_hit[h]) rd_val = mtimecmp[h][31:0];
            if (mcmp_hi_hit[h]) rd_val = mtimecmp[h][63:32];
            if (scmp_lo_hit[h]) rd_val = stimecmp[h][31:0];
            if (scmp_hi_hit[h]) rd_val = stimecmp[h][63:32];
        end
        if (ctrl_hit)  rd_val = {31'd0, en};
        if (presc_hit) rd_val = 32'(prescale);
        if (mtlo_hit)  rd_val = mtime[31:0];
        if (mthi_hit)  rd_val = mtime[63:32];
    end

    // ------------------------------------------------------------ handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = S_IDLE;
        bus.ack    = 1'b0;
        bus.err    = 1'b0;
        bus.rdata  = '0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = mapped ? S_ACK : S_ERR;
                end
            end
            S_ACK: begin
                // A master that drops cyc early gets no ack and no data.
                bus.ack   = bus.cyc;
                bus.rdata = bus.cyc ? rdata_q : '0;
            end
            S_ERR: begin
                bus.err = bus.cyc;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= (req && !bus.we) ? rd_val : '0;
        end
    end

    // ------------------------------------------------------ prescaler/mtime
    assign tick = en && (cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en       <= 1'b1;
            prescale <= PRESC_RST;
            cnt      <= '0;
            mtime    <= '0;
        end else begin
            if (wr && ctrl_hit && bus.sel[0]) begin
                en <= bus.wdata[0];
            end

            if (wr && presc_hit) begin
                prescale <= DIV_WIDTH'(lane_merge(32'(prescale), bus.wdata, bus.sel));
                cnt      <= '0;
            end else if (tick) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= cnt + DIV_WIDTH'(1);
            end

            // A bus write beats the tick: the untouched half keeps its pre-tick value.
            if (mtime_wr) begin
                if (mtlo_hit) mtime[31:0]  <= lane_merge(mtime[31:0],  bus.wdata, bus.sel);
                if (mthi_hit) mtime[63:32] <= lane_merge(mtime[63:32], bus.wdata, bus.sel);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
        end
    end

    // ------------------------------------------------------- per-hart state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msip <= '0;
            ssip <= '0;
            for (int h = 0; h < NHART; h++) begin
                mtimecmp[h] <= CMP_RST;
                stimecmp[h] <= CMP_RST;
            end
        end else if (wr) begin
            for (int h = 0; h < NHART; h++) begin
                if (msip_hit[h] && bus.sel[0]) msip[h] <= bus.wdata[0];
                if (ssip_hit[h] && bus.sel[0]) ssip[h] <= bus.wdata[0];
                if (mcmp_lo_hit[h])
                    mtimecmp[h][31:0]  <= lane_merge(mtimecmp[h][31:0],  bus.wdata, bus.sel);
                if (mcmp_hi_hit[h])
                    mtimecmp[h][63:32] <= lane_merge(mtimecmp[h][63:32], bus.wdata, bus.sel);
                if (scmp_lo_hit[h])
                    stimecmp[h][31:0]  <= lane_merge(stimecmp[h][31:0],  bus.wdata, bus.sel);
                if (scmp_hi_hit[h])
                    stimecmp[h][63:32] <= lane_merge(stimecmp[h][63:32], bus.wdata, bus.sel);
            end
        end
    end

    // Interrupt lines are registered copies of the current register state,
    // so they follow any register update by exactly one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msoft_q <= '0;
            ssoft_q <= '0;
            mtmr_q  <= '0;
            stmr_q  <= '0;
        end else begin
            msoft_q <= msip;
            ssoft_q <= ssip;
            for (int h = 0; h < NHART; h++) begin
                mtmr_q[h] <= (mtime >= mtimecmp[h]);
                stmr_q[h] <= (mtime >= stimecmp[h]);
            end
        end
    end

    assign clint_core_msoft_irq_o = msoft_q;
    assign clint_core_ssoft_irq_o = ssoft_q;
    assign clint_core_mtmr_irq_o  = mtmr_q;
    assign clint_core_stmr_irq_o  = stmr_q;

endmodule
